bsg_counter_up_down_sat: RTL and testbench

Parametrised up/down counter with multi-unit steps, selectable saturate or wrap behaviour at the range limits, a synchronous clear, and sticky overflow/underflow flags. It is the general successor to the fixed-range single-step up/down counter. It sits in credit-return and occupancy-tracking paths, where several credits can arrive or be consumed in one cycle and an out-of-range event must be reported instead of silently corrupting the count.

---
 rtl/bsg_counter_up_down_sat_pkg.sv | 17 +
 rtl/bsg_counter_up_down_sat_if.sv | 30 +++
 rtl/bsg_counter_up_down_sat_next.sv | 40 ++++
 rtl/bsg_counter_up_down_sat.sv | 62 ++++++
 tb/tb_bsg_counter_up_down_sat.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/bsg_counter_up_down_sat_pkg.sv
// Shared types for the saturating/wrapping up/down counter.
// Classifies a signed net sum against the legal count range.
package bsg_counter_up_down_sat_pkg;

  typedef enum logic [1:0] {
    RangeOk,
    RangeOver,
    RangeUnder
  } range_e;

  function automatic range_e classify(input int sum, input int max_val);
    if (sum > max_val) return RangeOver;
    if (sum < 0) return RangeUnder;
    return RangeOk;
  endfunction

endpackage

// File: rtl/bsg_counter_up_down_sat_if.sv
// Step/clear inputs and count/flag outputs of the up/down counter.
// master drives steps and clear; slave is the counter.
interface bsg_counter_up_down_sat_if
  import bsg_counter_up_down_sat_pkg::*;
#(
  parameter int unsigned max_val_p  = 200,
  parameter int unsigned max_step_p = 1
);
  localparam int unsigned ptr_width_lp  = $clog2(max_val_p + 1);
  localparam int unsigned step_width_lp = $clog2(max_step_p + 1);

  logic                     clear_i;
  logic [step_width_lp-1:0] up_i;
  logic [step_width_lp-1:0] down_i;
  logic [ptr_width_lp-1:0]  count_o;
  logic                     full_o;
  logic                     empty_o;
  logic                     overflow_o;
  logic                     underflow_o;

  modport master (
    output clear_i, up_i, down_i,
    input  count_o, full_o, empty_o, overflow_o, underflow_o
  );

  modport slave (
    input  clear_i, up_i, down_i,
    output count_o, full_o, empty_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/bsg_counter_up_down_sat_next.sv
// Combinational next-count: nets up against down, then saturates or wraps
// an out-of-range result and flags which limit was crossed.
module bsg_counter_up_down_sat_next
  import bsg_counter_up_down_sat_pkg::*;
#(
  parameter int unsigned max_val_p  = 200,
  parameter int unsigned max_step_p = 1,
  parameter bit          saturate_p = 1'b1,
  localparam int unsigned ptr_width_lp  = $clog2(max_val_p + 1),
  localparam int unsigned step_width_lp = $clog2(max_step_p + 1)
) (
  input  logic [ptr_width_lp-1:0]  count_i,
  input  logic [step_width_lp-1:0] up_i,
  input  logic [step_width_lp-1:0] down_i,
  output logic [ptr_width_lp-1:0]  count_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);
  // Two extra bits: one for headroom above max_val_p, one for sign.
  localparam int unsigned sum_width_lp = ptr_width_lp + 2;
  localparam logic [sum_width_lp-1:0] modulus_lp = sum_width_lp'(max_val_p + 1);

  logic signed [sum_width_lp-1:0] sum;
  range_e                         range;

  always_comb begin
    sum = signed'(sum_width_lp'(count_i) + sum_width_lp'(up_i) - sum_width_lp'(down_i));
    range = classify(int'(sum), int'(max_val_p));
    overflow_o  = (range == RangeOver);
    underflow_o = (range == RangeUnder);
    unique case (range)
      RangeOk:    count_o = ptr_width_lp'(sum);
      RangeOver:  count_o = saturate_p ? ptr_width_lp'(max_val_p)
                                       : ptr_width_lp'(sum - modulus_lp);
      RangeUnder: count_o = saturate_p ? '0 : ptr_width_lp'(sum + modulus_lp);
      default:    count_o = count_i;
    endcase
  end

endmodule

// File: rtl/bsg_counter_up_down_sat.sv
// Multi-step up/down counter with saturate-or-wrap limits, synchronous
// clear and sticky overflow/underflow flags.
module bsg_counter_up_down_sat
  import bsg_counter_up_down_sat_pkg::*;
#(
  parameter int unsigned max_val_p  = 200,
  parameter int unsigned init_val_p = 200,
  parameter int unsigned max_step_p = 1,
  parameter bit          saturate_p = 1'b1
) (
  input logic                      clk_i,
  input logic                      reset_i,
  bsg_counter_up_down_sat_if.slave ctr
);
  localparam int unsigned ptr_width_lp = $clog2(max_val_p + 1);
  localparam logic [ptr_width_lp-1:0] init_lp = ptr_width_lp'(init_val_p);
  localparam logic [ptr_width_lp-1:0] max_lp  = ptr_width_lp'(max_val_p);

  if (init_val_p > max_val_p) begin : g_bad_init
    $error("init_val_p must not exceed max_val_p");
  end
  if (max_step_p < 1 || max_step_p > max_val_p) begin : g_bad_step
    $error("max_step_p must lie in 1..max_val_p");
  end

  logic [ptr_width_lp-1:0] count_q, count_d;
  logic                    overflow_q, underflow_q;
  logic                    step_over, step_under;

  bsg_counter_up_down_sat_next #(
    .max_val_p  (max_val_p),
    .max_step_p (max_step_p),
    .saturate_p (saturate_p)
  ) u_next (
    .count_i     (count_q),
    .up_i        (ctr.up_i),
    .down_i      (ctr.down_i),
    .count_o     (count_d),
    .overflow_o  (step_over),
    .underflow_o (step_under)
  );

  // Reset and clear have identical effect; clear discards same-cycle steps.
  always_ff @(posedge clk_i) begin
    if (reset_i || ctr.clear_i) begin
      count_q     <= init_lp;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_q | step_over;
      underflow_q <= underflow_q | step_under;
    end
  end

  assign ctr.count_o     = count_q;
  assign ctr.full_o      = (count_q == max_lp);
  assign ctr.empty_o     = (count_q == '0);
  assign ctr.overflow_o  = overflow_q;
  assign ctr.underflow_o = underflow_q;

endmodule

// File: tb/tb_bsg_counter_up_down_sat.sv
// Directed and scoreboarded checks of bsg_counter_up_down_sat across
// saturate/wrap configurations.
module tb_bsg_counter_up_down_sat;

  localparam int MaxVal = 200;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // a: init 200 step 1 sat; b: init 0 step 4 sat; c: init 198 step 4 wrap
  bsg_counter_up_down_sat_if #(.max_val_p(200), .max_step_p(1)) if_a ();
  bsg_counter_up_down_sat_if #(.max_val_p(200), .max_step_p(4)) if_b ();
  bsg_counter_up_down_sat_if #(.max_val_p(200), .max_step_p(4)) if_c ();

  bsg_counter_up_down_sat #(
    .max_val_p(200), .init_val_p(200), .max_step_p(1), .saturate_p(1'b1)
  ) dut_a (.clk_i(clk), .reset_i(rst), .ctr(if_a));

  bsg_counter_up_down_sat #(
    .max_val_p(200), .init_val_p(0), .max_step_p(4), .saturate_p(1'b1)
  ) dut_b (.clk_i(clk), .reset_i(rst), .ctr(if_b));

  bsg_counter_up_down_sat #(
    .max_val_p(200), .init_val_p(198), .max_step_p(4), .saturate_p(1'b0)
  ) dut_c (.clk_i(clk), .reset_i(rst), .ctr(if_c));

  always @(posedge clk) begin
    assert (if_a.up_i <= 1 && if_a.down_i <= 1) else $error("illegal step on a");
    assert (if_b.up_i <= 4 && if_b.down_i <= 4) else $error("illegal step on b");
    assert (if_c.up_i <= 4 && if_c.down_i <= 4) else $error("illegal step on c");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model(input int init, input bit sat, input int up, input int dn,
                       input bit clr, input bit rs,
                       inout int cnt, inout bit ov, inout bit un);
    int s;
    if (rs || clr) begin
      cnt = init; ov = 1'b0; un = 1'b0;
    end else begin
      s = cnt + up - dn;
      if (s > MaxVal) begin
        ov = 1'b1;
        cnt = sat ? MaxVal : s - (MaxVal + 1);
      end else if (s < 0) begin
        un = 1'b1;
        cnt = sat ? 0 : s + (MaxVal + 1);
      end else begin
        cnt = s;
      end
    end
  endtask

  int mb_cnt, mc_cnt;
  bit mb_ov, mb_un, mc_ov, mc_un;

  initial begin
    rst = 1'b1;
    if_a.clear_i = 1'b0; if_a.up_i = '0; if_a.down_i = '0;
    if_b.clear_i = 1'b0; if_b.up_i = '0; if_b.down_i = '0;
    if_c.clear_i = 1'b0; if_c.up_i = '0; if_c.down_i = '0;
    tick();
    tick();
    rst = 1'b0;

    check_eq("a_rst_cnt", 32'(if_a.count_o), 200);
    check_eq("a_rst_full", 32'(if_a.full_o), 1);
    check_eq("a_rst_empty", 32'(if_a.empty_o), 0);
    check_eq("a_rst_ov", 32'(if_a.overflow_o), 0);
    check_eq("a_rst_un", 32'(if_a.underflow_o), 0);
    check_eq("b_rst_cnt", 32'(if_b.count_o), 0);
    check_eq("b_rst_empty", 32'(if_b.empty_o), 1);
    check_eq("c_rst_cnt", 32'(if_c.count_o), 198);

    // Saturate at the top
    if_a.up_i = 1'b1;
    tick();
    if_a.up_i = 1'b0;
    check_eq("a_sat_cnt", 32'(if_a.count_o), 200);
    check_eq("a_sat_ov", 32'(if_a.overflow_o), 1);

    // Saturate at the bottom, then net steps keep the sticky flag
    if_b.down_i = 3'd3;
    tick();
    check_eq("b_under_cnt", 32'(if_b.count_o), 0);
    check_eq("b_under_un", 32'(if_b.underflow_o), 1);
    if_b.up_i = 3'd4; if_b.down_i = 3'd1;
    for (int i = 0; i < 5; i++) tick();
    if_b.up_i = 3'd0; if_b.down_i = 3'd0;
    check_eq("b_net_cnt", 32'(if_b.count_o), 15);
    check_eq("b_net_un", 32'(if_b.underflow_o), 1);
    check_eq("b_net_ov", 32'(if_b.overflow_o), 0);

    // Wrap past the top and below zero
    if_c.up_i = 3'd4;
    tick();
    check_eq("c_wrap_hi_cnt", 32'(if_c.count_o), 1);
    check_eq("c_wrap_hi_ov", 32'(if_c.overflow_o), 1);
    if_c.up_i = 3'd0; if_c.down_i = 3'd3;
    tick();
    if_c.down_i = 3'd0;
    check_eq("c_wrap_lo_cnt", 32'(if_c.count_o), 199);
    check_eq("c_wrap_lo_un", 32'(if_c.underflow_o), 1);
    // Exactly reaching max is in range
    if_c.up_i = 3'd1;
    tick();
    if_c.up_i = 3'd0;
    check_eq("c_full_cnt", 32'(if_c.count_o), 200);
    check_eq("c_full_full", 32'(if_c.full_o), 1);

    // Clear with a same-cycle step discards the step
    if_c.clear_i = 1'b1; if_c.up_i = 3'd4;
    tick();
    if_c.clear_i = 1'b0; if_c.up_i = 3'd0;
    check_eq("c_clr_cnt", 32'(if_c.count_o), 198);
    check_eq("c_clr_ov", 32'(if_c.overflow_o), 0);
    check_eq("c_clr_un", 32'(if_c.underflow_o), 0);

    // Equal up/down nets to no change
    if_b.clear_i = 1'b1;
    tick();
    if_b.clear_i = 1'b0;
    check_eq("b_clr_un", 32'(if_b.underflow_o), 0);
    if_b.up_i = 3'd4;
    for (int i = 0; i < 25; i++) tick();
    check_eq("b_100_cnt", 32'(if_b.count_o), 100);
    if_b.up_i = 3'd2; if_b.down_i = 3'd2;
    tick();
    check_eq("b_eq_cnt", 32'(if_b.count_o), 100);
    check_eq("b_eq_ov", 32'(if_b.overflow_o), 0);
    check_eq("b_eq_un", 32'(if_b.underflow_o), 0);
    if_b.up_i = 3'd3; if_b.down_i = 3'd1;
    tick();
    if_b.up_i = 3'd0; if_b.down_i = 3'd0;
    check_eq("b_net2_cnt", 32'(if_b.count_o), 102);

    // Random traffic with occasional clear and mid-run reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mb_cnt = 0;   mb_ov = 1'b0; mb_un = 1'b0;
    mc_cnt = 198; mc_ov = 1'b0; mc_un = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      int ub, db, uc, dc;
      bit rs, cb, cc;
      if ((i / 1000) % 2 == 0) begin
        ub = $urandom_range(4, 0); db = $urandom_range(2, 0);
        uc = $urandom_range(4, 0); dc = $urandom_range(2, 0);
      end else begin
        ub = $urandom_range(2, 0); db = $urandom_range(4, 0);
        uc = $urandom_range(2, 0); dc = $urandom_range(4, 0);
      end
      rs = ($urandom_range(1999, 0) == 0);
      cb = ($urandom_range(999, 0) == 0);
      cc = ($urandom_range(999, 0) == 0);
      rst = rs;
      if_b.clear_i = cb; if_b.up_i = 3'(ub); if_b.down_i = 3'(db);
      if_c.clear_i = cc; if_c.up_i = 3'(uc); if_c.down_i = 3'(dc);
      model(0, 1'b1, ub, db, cb, rs, mb_cnt, mb_ov, mb_un);
      model(198, 1'b0, uc, dc, cc, rs, mc_cnt, mc_ov, mc_un);
      tick();
      check_eq("rnd_b_cnt", 32'(if_b.count_o), 32'(mb_cnt));
      check_eq("rnd_b_ov", 32'(if_b.overflow_o), 32'(mb_ov));
      check_eq("rnd_b_un", 32'(if_b.underflow_o), 32'(mb_un));
      check_eq("rnd_c_cnt", 32'(if_c.count_o), 32'(mc_cnt));
      check_eq("rnd_c_ov", 32'(if_c.overflow_o), 32'(mc_ov));
      check_eq("rnd_c_un", 32'(if_c.underflow_o), 32'(mc_un));
    end

    // Reset wins over clear and steps
    if_b.up_i = 3'd4; if_b.clear_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if_b.up_i = 3'd0;
    check_eq("b_rstmid_cnt", 32'(if_b.count_o), 0);
    check_eq("b_rstmid_ov", 32'(if_b.overflow_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
